// File: rtl/sobel_grad_pkg.sv
// Shared constants, FSM state type and arithmetic helpers for the Sobel gradient block.
package sobel_grad_pkg;

    localparam int IMG_WIDTH_DEF  = 320;
    localparam int IMG_HEIGHT_DEF = 240;
    localparam int SOBEL_LATENCY  = 3;
    localparam int GRAD_W         = 11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic signed [GRAD_W-1:0] ext8(input logic [7:0] p);
        return $signed({3'b000, p});
    endfunction

    // One kernel leg: a + 2b + c, never exceeds 1020 so 11-bit signed is safe.
    function automatic logic signed [GRAD_W-1:0] leg_sum(input logic [7:0] a,
                                                         input logic [7:0] b,
                                                         input logic [7:0] c);
        return ext8(a) + (ext8(b) <<< 1) + ext8(c);
    endfunction

    function automatic logic [GRAD_W-1:0] abs11(input logic signed [GRAD_W-1:0] v);
        return v[GRAD_W-1] ? GRAD_W'(-v) : GRAD_W'(v);
    endfunction

endpackage

// File: rtl/sobel_grad_line_buffer.sv
// One line of luma storage: registered read, a read that collides with a write returns old data.
module line_buffer #(
    parameter int DEPTH = 320
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [7:0]               wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [7:0]               rdata_o
);
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Storage write and registered read; no reset on contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sobel_grad.sv
// Streaming 3x3 Sobel |Gx|+|Gy| over a raster luma stream.
// Two line buffers feed a 3x3 window; each result leaves three cycles after its pixel.
module sobel_grad
    import sobel_grad_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sof,
    input  logic                          pix_valid,
    input  logic [7:0]                    pix_in,
    output logic                          grad_valid,
    output logic [15:0]                   gradient,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_y
);
    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);

    state_e                   state_q;
    logic [XW-1:0]            x_q, x1_q, cx2_q, out_x_q, px;
    logic [YW-1:0]            y_q, y1_q, cy2_q, out_y_q, py;
    logic                     acc;
    logic [SOBEL_LATENCY-1:0] vld_q;
    logic [7:0]               pix1_q, rd_a, rd_b;
    logic [2:0][2:0][7:0]     win_q, win_d;
    logic signed [GRAD_W-1:0] gx, gy, gx_q, gy_q;
    logic [GRAD_W-1:0]        mag;
    logic [15:0]              gradient_q;

    // Pixel acceptance and position of the incoming pixel (sof resyncs to origin).
    always_comb begin
        acc = 1'b0;
        px  = x_q;
        py  = y_q;
        if (pix_valid && sof) begin
            acc = 1'b1;
            px  = '0;
            py  = '0;
        end else if (pix_valid && (state_q == ST_RUN)) begin
            acc = 1'b1;
        end else begin
            acc = 1'b0;
        end
    end

    // Frame FSM and raster counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
        end else if (acc) begin
            if (px == XW'(IMG_WIDTH - 1)) begin
                x_q <= '0;
                if (py == YW'(IMG_HEIGHT - 1)) begin
                    state_q <= ST_DONE;
                    y_q     <= '0;
                end else begin
                    state_q <= ST_RUN;
                    y_q     <= py + YW'(1);
                end
            end else begin
                state_q <= ST_RUN;
                x_q     <= px + XW'(1);
                y_q     <= py;
            end
        end
    end

    // A holds row y-1; B receives A's old word one cycle later, so it holds row y-2.
    line_buffer #(.DEPTH(IMG_WIDTH)) u_buf_a (
        .clk     (clk),
        .we_i    (acc),
        .waddr_i (px),
        .wdata_i (pix_in),
        .re_i    (acc),
        .raddr_i (px),
        .rdata_o (rd_a)
    );

    line_buffer #(.DEPTH(IMG_WIDTH)) u_buf_b (
        .clk     (clk),
        .we_i    (vld_q[0]),
        .waddr_i (x1_q),
        .wdata_i (rd_a),
        .re_i    (acc),
        .raddr_i (px),
        .rdata_o (rd_b)
    );

    // Window shift on accepted pixels, then both kernels on the updated window.
    always_comb begin
        win_d = win_q;
        if (vld_q[0]) begin
            for (int r = 0; r < 3; r++) begin
                win_d[r][0] = win_q[r][1];
                win_d[r][1] = win_q[r][2];
            end
            win_d[0][2] = rd_b;
            win_d[1][2] = rd_a;
            win_d[2][2] = pix1_q;
        end else begin
            win_d = win_q;
        end
        gx = leg_sum(win_d[0][2], win_d[1][2], win_d[2][2])
           - leg_sum(win_d[0][0], win_d[1][0], win_d[2][0]);
        gy = leg_sum(win_d[2][0], win_d[2][1], win_d[2][2])
           - leg_sum(win_d[0][0], win_d[0][1], win_d[0][2]);
        mag = abs11(gx_q) + abs11(gy_q);
    end

    // Valid tokens; only pixels with x>=1 and y>=1 carry a result past S1.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= acc;
            vld_q[1] <= vld_q[0] && (x1_q != '0) && (y1_q != '0);
            vld_q[2] <= vld_q[1];
        end
    end

    // Unreset datapath registers for S0/S1.
    always_ff @(posedge clk) begin
        if (acc) begin
            x1_q   <= px;
            y1_q   <= py;
            pix1_q <= pix_in;
        end
        win_q <= win_d;
        if (vld_q[0]) begin
            gx_q  <= gx;
            gy_q  <= gy;
            cx2_q <= x1_q - XW'(1);
            cy2_q <= y1_q - YW'(1);
        end
    end

    // Registered outputs; border centres are forced to zero to hide stale window data.
    always_ff @(posedge clk) begin
        if (rst) begin
            gradient_q <= 16'd0;
            out_x_q    <= '0;
            out_y_q    <= '0;
        end else if (vld_q[1]) begin
            gradient_q <= ((cx2_q == '0) || (cy2_q == '0)) ? 16'd0 : {5'b00000, mag};
            out_x_q    <= cx2_q;
            out_y_q    <= cy2_q;
        end
    end

    assign grad_valid = vld_q[SOBEL_LATENCY-1];
    assign gradient   = gradient_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;

endmodule

// File: tb/tb_sobel_grad.sv
// Bench for sobel_grad on an 8x8 frame: reference model scoreboard plus directed pattern tables.
module tb_sobel_grad;
    localparam int W = 8;
    localparam int H = 8;

    typedef struct {
        int cyc;
        int x;
        int y;
        int g;
    } exp_t;

    typedef struct {
        int pat;
        int cx;
        int cy;
        int g;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, sof, pix_valid;
    logic [7:0] pix_in;
    logic       grad_valid;
    logic [15:0] gradient;
    logic [2:0] out_x, out_y;

    int   cyc = 0;
    int   n_chk = 0, n_fail = 0, n_out = 0;
    int   mst = 0, mx = 0, my = 0;
    int   img [H][W];
    int   rnd_img [H][W];
    int   cap [H][W];
    int   cap0 [H][W];
    int   cur_pat = 0;
    exp_t q [$];
    vec_t tbl [18];

    sobel_grad #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .grad_valid (grad_valid),
        .gradient   (gradient),
        .out_x      (out_x),
        .out_y      (out_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic int pix_of(int pat, int x, int y);
        case (pat)
            0:       return 128;
            1:       return (x < 4) ? 0 : 255;
            2:       return (x == 5 && y == 5) ? 255 : 0;
            default: return rnd_img[y][x];
        endcase
    endfunction

    function automatic int sobel_ref(int cx, int cy);
        int gx, gy;
        gx = (img[cy-1][cx+1] + 2*img[cy][cx+1] + img[cy+1][cx+1])
           - (img[cy-1][cx-1] + 2*img[cy][cx-1] + img[cy+1][cx-1]);
        gy = (img[cy+1][cx-1] + 2*img[cy+1][cx] + img[cy+1][cx+1])
           - (img[cy-1][cx-1] + 2*img[cy-1][cx] + img[cy-1][cx+1]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return gx + gy;
    endfunction

    // Reference: raster position, frame image, expected result due 3 cycles later.
    task automatic model_accept(input bit s, input int p);
        exp_t e;
        if (s) begin
            mst = 1; mx = 0; my = 0;
        end
        if (mst == 1) begin
            img[my][mx] = p;
            if (mx >= 1 && my >= 1) begin
                e.cyc = cyc + 3;
                e.x   = mx - 1;
                e.y   = my - 1;
                e.g   = (e.x == 0 || e.y == 0) ? 0 : sobel_ref(e.x, e.y);
                q.push_back(e);
            end
            if (mx == W - 1) begin
                mx = 0;
                if (my == H - 1) begin
                    mst = 2; my = 0;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            sof = 1'b0; pix_valid = 1'b0;
        end
    endtask

    task automatic drive_pix(input bit s, input int p);
        @(posedge clk); #1;
        sof = s; pix_valid = 1'b1; pix_in = p[7:0];
        model_accept(s, p);
    endtask

    task automatic send_range(input int start, input int count, input bit sof_first, input int gap_max);
        for (int i = start; i < start + count; i++) begin
            int x, y;
            x = i % W;
            y = i / W;
            idle($urandom_range(gap_max, 0));
            drive_pix(sof_first && (i == start), pix_of(cur_pat, x, y));
        end
    endtask

    task automatic run_frame(input int gap_max, input int exp_n);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) cap[y][x] = -1;
        send_range(0, W*H, 1'b1, gap_max);
        idle(6);
        chk("outputs_per_frame", n_out, exp_n);
    endtask

    task automatic check_table(input int pat);
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].pat == pat) chk("pattern_centre", cap[tbl[i].cy][tbl[i].cx], tbl[i].g);
        end
    endtask

    task automatic new_random_img();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) rnd_img[y][x] = $urandom_range(255, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; sof = 1'b0; pix_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        mst = 0;
        @(negedge clk);
        chk("reset_valid", grad_valid, 0);
        chk("reset_gradient", gradient, 0);
        chk("reset_out_x", out_x, 0);
        chk("reset_out_y", out_y, 0);
    endtask

    // Scoreboard: each expected result must appear exactly on its due cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                while (q.size() > 0 && q[0].cyc < cyc) begin
                    e = q.pop_front();
                    chk("missed_output", 0, 1);
                end
                if (q.size() > 0 && q[0].cyc == cyc) begin
                    e = q.pop_front();
                    chk("grad_valid_due", grad_valid, 1);
                    if (grad_valid === 1'b1) begin
                        chk("gradient", gradient, e.g);
                        chk("out_x", out_x, e.x);
                        chk("out_y", out_y, e.y);
                        cap[e.y][e.x] = gradient;
                        n_out++;
                    end
                end else begin
                    chk("grad_valid_idle", grad_valid, 0);
                end
            end
        end
    end

    initial begin
        tbl[0]  = '{0, 3, 3, 0};    tbl[1]  = '{0, 1, 1, 0};    tbl[2]  = '{0, 6, 6, 0};
        tbl[3]  = '{1, 3, 2, 1020}; tbl[4]  = '{1, 4, 5, 1020}; tbl[5]  = '{1, 3, 6, 1020};
        tbl[6]  = '{1, 2, 3, 0};    tbl[7]  = '{1, 5, 3, 0};    tbl[8]  = '{1, 3, 0, 0};
        tbl[9]  = '{1, 6, 6, 0};    tbl[10] = '{2, 4, 5, 510};  tbl[11] = '{2, 5, 4, 510};
        tbl[12] = '{2, 4, 4, 510};  tbl[13] = '{2, 5, 5, 0};    tbl[14] = '{2, 6, 6, 510};
        tbl[15] = '{2, 6, 5, 510};  tbl[16] = '{2, 3, 5, 0};    tbl[17] = '{2, 2, 2, 0};

        rst = 1'b1; sof = 1'b0; pix_valid = 1'b0; pix_in = 8'd0;
        repeat (3) @(posedge clk);
        do_reset();

        // Pixels before the first sof are ignored.
        cur_pat = 3;
        new_random_img();
        send_range(5, 6, 1'b0, 0);
        idle(4);

        for (int pat = 0; pat < 3; pat++) begin
            cur_pat = pat;
            n_out = 0;
            run_frame(0, 49);
            check_table(pat);
        end

        // Non-sof pixels after a completed frame are ignored.
        send_range(0, 5, 1'b0, 0);
        idle(4);

        // Gapless then gapped run of the same random frame must match.
        cur_pat = 3;
        new_random_img();
        n_out = 0;
        run_frame(0, 49);
        cap0 = cap;
        n_out = 0;
        run_frame(5, 49);
        for (int y = 0; y < H - 1; y++)
            for (int x = 0; x < W - 1; x++) chk("gap_vs_gapless", cap[y][x], cap0[y][x]);

        // Reset arriving at pixel (3,3), then stale pixels, then a fresh frame.
        new_random_img();
        send_range(0, 27, 1'b1, 0);
        do_reset();
        send_range(0, 4, 1'b0, 0);
        idle(5);
        new_random_img();
        n_out = 0;
        run_frame(0, 49);

        // Resync at x=5 of row 2, then a normal frame.
        new_random_img();
        n_out = 0;
        send_range(0, 21, 1'b1, 0);
        run_frame(0, 60);
        n_out = 0;
        run_frame(2, 49);

        // sof on what would be the final pixel of a frame.
        new_random_img();
        n_out = 0;
        send_range(0, W*H - 1, 1'b1, 0);
        run_frame(0, 97);

        idle(4);
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
